// File: rtl/tile_fetch_arbiter.sv
// tile_fetch_arbiter
//   Shares one combinational tile-graphic lookup port among NUM_REQ renderers.
//   A round-robin arbiter grants one requester per cycle. That requester's
//   tile/x/y drive the graphic mux. The looked-up colour is captured in a
//   1-deep response register with valid/ready flow control.
// Ports
//   i_clk, i_rst_n           clock; asynchronous active-low reset
//   i_req                    per-requester request, held until granted
//   i_req_tile/_x/_y         packed per-requester fields, requester i at [i*W +: W]
//   o_gnt                    one-hot accept pulse (combinational)
//   o_gfx_tile/_x/_y         lookup address to the graphic mux (0 when idle)
//   i_gfx_pixel              combinational lookup result
//   o_rsp_valid, i_rsp_ready response handshake
//   o_rsp_id/_pixel/_oob     requester index, colour, out-of-range flag
module tile_fetch_arbiter #(
  parameter int NUM_REQ          = 4,
  parameter int REL_BITS         = 7,
  parameter int PIXELS_WIDTH     = 80,
  parameter int PIXEL_COLOR_BITS = 8,
  parameter int TILE_ID_BITS     = 3
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic [NUM_REQ-1:0]                 i_req,
  input  logic [NUM_REQ*TILE_ID_BITS-1:0]    i_req_tile,
  input  logic [NUM_REQ*REL_BITS-1:0]        i_req_x,
  input  logic [NUM_REQ*REL_BITS-1:0]        i_req_y,
  output logic [NUM_REQ-1:0]                 o_gnt,
  output logic [TILE_ID_BITS-1:0]            o_gfx_tile,
  output logic [REL_BITS-1:0]                o_gfx_x,
  output logic [REL_BITS-1:0]                o_gfx_y,
  input  logic [PIXEL_COLOR_BITS-1:0]        i_gfx_pixel,
  output logic                               o_rsp_valid,
  input  logic                               i_rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]         o_rsp_id,
  output logic [PIXEL_COLOR_BITS-1:0]        o_rsp_pixel,
  output logic                               o_rsp_oob
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [REL_BITS-1:0] PW = REL_BITS'(PIXELS_WIDTH);

  logic [NUM_REQ-1:0][TILE_ID_BITS-1:0] w_tile;
  logic [NUM_REQ-1:0][REL_BITS-1:0]     w_x, w_y;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_tile[g] = i_req_tile[g*TILE_ID_BITS +: TILE_ID_BITS];
    assign w_x[g]    = i_req_x[g*REL_BITS +: REL_BITS];
    assign w_y[g]    = i_req_y[g*REL_BITS +: REL_BITS];
  end

  logic [IDW-1:0]              r_ptr;
  logic                        r_rsp_valid;
  logic [IDW-1:0]              r_rsp_id;
  logic [PIXEL_COLOR_BITS-1:0] r_rsp_pixel;
  logic                        r_rsp_oob;

  logic           w_found;
  logic [IDW-1:0] w_sel;
  logic [IDW:0]   w_idx;   // one extra bit so ptr+j cannot overflow before the wrap
  logic           w_grant;
  logic           w_oob;

  // Rotating priority search starting at r_ptr; first set request wins.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_idx = {1'b0, r_ptr} + (IDW+1)'(j);
      if (w_idx >= (IDW+1)'(NUM_REQ)) w_idx = w_idx - (IDW+1)'(NUM_REQ);
      if (!w_found && i_req[w_idx[IDW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_idx[IDW-1:0];
      end
    end
  end

  // Gating with i_rst_n keeps gnt low during the whole reset window, not just at the edge.
  assign w_grant = i_rst_n && w_found && (!r_rsp_valid || i_rsp_ready);
  assign w_oob   = (w_x[w_sel] >= PW) || (w_y[w_sel] >= PW);

  assign o_gnt      = w_grant ? (NUM_REQ'(1) << w_sel) : '0;
  assign o_gfx_tile = w_grant ? w_tile[w_sel] : '0;
  assign o_gfx_x    = w_grant ? w_x[w_sel]    : '0;
  assign o_gfx_y    = w_grant ? w_y[w_sel]    : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_pixel <= '0;
      r_rsp_oob   <= 1'b0;
    end else if (w_grant) begin
      r_ptr       <= (w_sel == IDW'(NUM_REQ-1)) ? '0 : w_sel + 1'b1;
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= w_sel;
      r_rsp_oob   <= w_oob;
      r_rsp_pixel <= w_oob ? '0 : i_gfx_pixel;
    end else if (i_rsp_ready) begin
      // Consumed with nothing new: drop valid, keep the data fields.
      r_rsp_valid <= 1'b0;
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_pixel = r_rsp_pixel;
  assign o_rsp_oob   = r_rsp_oob;
endmodule

// File: tb/tb_tile_fetch_arbiter.sv
// Directed bench for tile_fetch_arbiter (NUM_REQ=4). Inputs change on the
// falling edge; registered outputs are checked at the falling edge, grant-side
// combinational outputs 1 time unit after the inputs change.
module tb_tile_fetch_arbiter;
  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       req;
  logic [3:0][2:0]  tile_a;
  logic [3:0][6:0]  x_a, y_a;
  logic [3:0]       gnt;
  logic [2:0]       gfx_tile;
  logic [6:0]       gfx_x, gfx_y;
  logic [7:0]       gfx_pixel;
  logic             rsp_valid, rsp_ready, rsp_oob;
  logic [1:0]       rsp_id;
  logic [7:0]       rsp_pixel;
  logic             ovr_en;
  logic [7:0]       ovr_pix;
  logic [7:0]       pix [4];
  int               nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  // Stand-in graphic ROM: colour built from the lookup address.
  assign gfx_pixel = ovr_en ? ovr_pix : {gfx_tile, gfx_x[2:0], gfx_y[1:0]};

  tile_fetch_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req),
    .i_req_tile(tile_a), .i_req_x(x_a), .i_req_y(y_a),
    .o_gnt(gnt), .o_gfx_tile(gfx_tile), .o_gfx_x(gfx_x), .o_gfx_y(gfx_y),
    .i_gfx_pixel(gfx_pixel), .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_id(rsp_id), .o_rsp_pixel(rsp_pixel), .o_rsp_oob(rsp_oob));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic [1:0] id,
                         input logic [7:0] p, input logic oob);
    chk({tag, ".valid"}, rsp_valid, v);
    chk({tag, ".id"},    rsp_id,    id);
    chk({tag, ".pixel"}, rsp_pixel, p);
    chk({tag, ".oob"},   rsp_oob,   oob);
  endtask

  initial begin
    // requester i: tile=i, x=10+i, y=20+i -> colour {i, (2+i)&7, i&3}
    pix[0] = 8'h08; pix[1] = 8'h2D; pix[2] = 8'h52; pix[3] = 8'h77;
    for (int i = 0; i < 4; i++) begin
      tile_a[i] = 3'(i); x_a[i] = 7'(10 + i); y_a[i] = 7'(20 + i);
    end
    ovr_en = 1'b0; ovr_pix = 8'h00;
    rst_n = 1'b0; req = 4'b1111; rsp_ready = 1'b1;

    // 1 reset with all requests high
    #1;
    chk("rst.gnt", gnt, 4'b0000);
    chk_rsp("rst", 1'b0, 2'd0, 8'h00, 1'b0);
    chk("rst.gfx_x", gfx_x, 7'd0);
    @(negedge clk);
    chk("rst2.gnt", gnt, 4'b0000);
    chk("rst2.valid", rsp_valid, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("rel.gnt", gnt, 4'b0001);
    chk("rel.gfx_x", gfx_x, 7'd10);
    chk("rel.gfx_y", gfx_y, 7'd20);

    // 2 all requesting, always ready: rotation and full throughput
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk_rsp($sformatf("rr%0d", c), 1'b1, 2'((c - 1) % 4), pix[(c - 1) % 4], 1'b0);
      if (c < 8) begin
        #1;
        chk($sformatf("rr%0d.gnt", c), gnt, 4'b0001 << (c % 4));
        chk($sformatf("rr%0d.gfx_tile", c), gfx_tile, 3'(c % 4));
      end
    end

    // 3 backpressure (ptr is back at 0)
    req = 4'b0100; x_a[2] = 7'd10; y_a[2] = 7'd10;
    #1;
    chk("bp.gnt0", gnt, 4'b0100);
    chk("bp.gfx_x", gfx_x, 7'd10);
    @(negedge clk);
    chk_rsp("bp.load", 1'b1, 2'd2, 8'h4A, 1'b0);
    rsp_ready = 1'b0; x_a[2] = 7'd11;
    #1;
    chk("bp.stall.gnt", gnt, 4'b0000);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk_rsp($sformatf("bp.hold%0d", c), 1'b1, 2'd2, 8'h4A, 1'b0);
      chk($sformatf("bp.hold%0d.gnt", c), gnt, 4'b0000);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp.resume.gnt", gnt, 4'b0100);
    chk("bp.resume.gfx_x", gfx_x, 7'd11);
    @(negedge clk);
    chk_rsp("bp.reload", 1'b1, 2'd2, 8'h4E, 1'b0);
    req = 4'b0000;
    #1;
    chk("bp.idle.gnt", gnt, 4'b0000);
    chk("bp.idle.gfx_tile", gfx_tile, 3'd0);
    @(negedge clk);
    chk_rsp("bp.drain", 1'b0, 2'd2, 8'h4E, 1'b0);

    // 4 out-of-range coordinates (ptr=3)
    ovr_en = 1'b1; ovr_pix = 8'hC0;
    req = 4'b0010; x_a[1] = 7'd80; y_a[1] = 7'd5;
    #1;
    chk("oob.gnt", gnt, 4'b0010);
    @(negedge clk);
    chk_rsp("oob.x80", 1'b1, 2'd1, 8'h00, 1'b1);
    x_a[1] = 7'd79;
    @(negedge clk);
    chk_rsp("oob.x79", 1'b1, 2'd1, 8'hC0, 1'b0);
    x_a[1] = 7'd5; y_a[1] = 7'd80;
    @(negedge clk);
    chk_rsp("oob.y80", 1'b1, 2'd1, 8'h00, 1'b1);
    x_a[1] = 7'd11; y_a[1] = 7'd21; ovr_en = 1'b0;
    req = 4'b0000;
    @(negedge clk);
    chk("oob.drain.valid", rsp_valid, 1'b0);

    // 5 fairness (ptr=2)
    req = 4'b0001;
    #1; chk("fair.a.gnt", gnt, 4'b0001);
    @(negedge clk);
    chk("fair.a.id", rsp_id, 2'd0);
    req = 4'b1001;
    #1; chk("fair.b.gnt", gnt, 4'b1000);
    @(negedge clk);
    chk("fair.b.id", rsp_id, 2'd3);
    #1; chk("fair.c.gnt", gnt, 4'b0001);
    @(negedge clk);
    chk("fair.c.id", rsp_id, 2'd0);
    req = 4'b0001;
    #1; chk("fair.d.gnt", gnt, 4'b0001);
    @(negedge clk);
    chk_rsp("fair.d", 1'b1, 2'd0, pix[0], 1'b0);

    // 6 async reset during a stall (ptr=1 beforehand)
    rsp_ready = 1'b0; req = 4'b0010;
    #1; chk("ars.stall.gnt", gnt, 4'b0000);
    #2; rst_n = 1'b0;
    #1;
    chk_rsp("ars", 1'b0, 2'd0, 8'h00, 1'b0);
    chk("ars.gnt", gnt, 4'b0000);
    @(negedge clk);
    chk("ars.hold.valid", rsp_valid, 1'b0);
    rst_n = 1'b1; req = 4'b1111; rsp_ready = 1'b1;
    #1; chk("ars.rel.gnt", gnt, 4'b0001);
    @(negedge clk);
    chk_rsp("ars.first", 1'b1, 2'd0, pix[0], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
